// File: rtl/sap_pkg.sv
// Shared definitions for the SAP control sequencer: opcodes, control-word
// bit positions, control constants and the per-opcode final-step lookup.
package sap_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'he;
  localparam logic [3:0] OP_HLT = 4'hf;

  localparam int unsigned BIT_HLT = 15;
  localparam int unsigned BIT_MI  = 14;
  localparam int unsigned BIT_RI  = 13;
  localparam int unsigned BIT_RO  = 12;
  localparam int unsigned BIT_IO  = 11;
  localparam int unsigned BIT_II  = 10;
  localparam int unsigned BIT_AI  = 9;
  localparam int unsigned BIT_AO  = 8;
  localparam int unsigned BIT_EO  = 7;
  localparam int unsigned BIT_SU  = 6;
  localparam int unsigned BIT_BI  = 5;
  localparam int unsigned BIT_OI  = 4;
  localparam int unsigned BIT_CE  = 3;
  localparam int unsigned BIT_CO  = 2;
  localparam int unsigned BIT_J   = 1;
  localparam int unsigned BIT_FI  = 0;

  localparam logic [15:0] CW_HLT = 16'h8000;
  localparam logic [15:0] CW_MI  = 16'h4000;
  localparam logic [15:0] CW_RI  = 16'h2000;
  localparam logic [15:0] CW_RO  = 16'h1000;
  localparam logic [15:0] CW_IO  = 16'h0800;
  localparam logic [15:0] CW_II  = 16'h0400;
  localparam logic [15:0] CW_AI  = 16'h0200;
  localparam logic [15:0] CW_AO  = 16'h0100;
  localparam logic [15:0] CW_EO  = 16'h0080;
  localparam logic [15:0] CW_SU  = 16'h0040;
  localparam logic [15:0] CW_BI  = 16'h0020;
  localparam logic [15:0] CW_OI  = 16'h0010;
  localparam logic [15:0] CW_CE  = 16'h0008;
  localparam logic [15:0] CW_CO  = 16'h0004;
  localparam logic [15:0] CW_J   = 16'h0002;
  localparam logic [15:0] CW_FI  = 16'h0001;

  localparam logic [15:0] CW_NONE  = 16'h0000;
  localparam logic [15:0] FETCH_T0 = CW_CO | CW_MI;
  localparam logic [15:0] FETCH_T1 = CW_RO | CW_II | CW_CE;

  // Last useful T-state of each instruction; HLT never gets past T2.
  function automatic logic [2:0] early_last_step(input logic [3:0] op);
    logic [2:0] last;
    case (op)
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last = 3'd2;
      OP_LDA, OP_STA:                               last = 3'd3;
      OP_ADD, OP_SUB:                               last = 3'd4;
      default:                                      last = 3'd1;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/sap_microcode_rom.sv
// Combinational microcode: maps (T-state, opcode, flags) to the 16-bit
// control word. Each word enables at most one bus driver.
module sap_microcode_rom
  import sap_pkg::*;
(
  input  logic [2:0]  step,
  input  logic [3:0]  opcode,
  input  logic        carry_f,
  input  logic        zero_f,
  output logic [15:0] word
);

  // Microcode lookup; unlisted step/opcode pairs decode to an empty word.
  always_comb begin
    word = CW_NONE;
    case (step)
      3'd0: word = FETCH_T0;
      3'd1: word = FETCH_T1;
      3'd2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: word = CW_IO | CW_MI;
          OP_LDI: word = CW_IO | CW_AI;
          OP_JMP: word = CW_IO | CW_J;
          OP_JC: begin
            if (carry_f) begin
              word = CW_IO | CW_J;
            end else begin
              word = CW_NONE;
            end
          end
          OP_JZ: begin
            if (zero_f) begin
              word = CW_IO | CW_J;
            end else begin
              word = CW_NONE;
            end
          end
          OP_OUT: word = CW_AO | CW_OI;
          OP_HLT: word = CW_HLT;
          default: word = CW_NONE;
        endcase
      end
      3'd3: begin
        case (opcode)
          OP_LDA:         word = CW_RO | CW_AI;
          OP_ADD, OP_SUB: word = CW_RO | CW_BI;
          OP_STA:         word = CW_AO | CW_RI;
          default:        word = CW_NONE;
        endcase
      end
      3'd4: begin
        case (opcode)
          OP_ADD:  word = CW_EO | CW_AI | CW_FI;
          OP_SUB:  word = CW_EO | CW_AI | CW_SU | CW_FI;
          default: word = CW_NONE;
        endcase
      end
      default: word = CW_NONE;
    endcase
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP T-state sequencer: owns the step counter and halt latch, and gates the
// microcode word so each microstep is presented only on an advancing cycle.
module sap_control_sequencer
  import sap_pkg::*;
#(
  parameter int unsigned LAST_STEP = 4,
  parameter bit          EARLY_END = 1'b0
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        run,
  input  logic        step_mode,
  input  logic        step_req,
  input  logic [3:0]  opcode,
  input  logic        carry_f,
  input  logic        zero_f,
  output logic [15:0] ctrl_word,
  output logic [2:0]  step,
  output logic        halted
);

  localparam logic [2:0] LAST_S = 3'(LAST_STEP);

  logic [2:0]  step_r;
  logic        halted_r;
  logic [2:0]  step_nxt_s;
  logic        halted_nxt_s;
  logic [2:0]  early_last_s;
  logic [2:0]  last_s;
  logic        advance_s;
  logic        halt_hit_s;
  logic [15:0] rom_word_s;

  sap_microcode_rom u_rom (
    .step    (step_r),
    .opcode  (opcode),
    .carry_f (carry_f),
    .zero_f  (zero_f),
    .word    (rom_word_s)
  );

  assign advance_s    = clr_n & run & ~halted_r & (~step_mode | step_req);
  assign halt_hit_s   = advance_s && (step_r == 3'd2) && (opcode == OP_HLT);
  assign early_last_s = early_last_step(opcode);

  // Wrap point: the per-opcode last step never exceeds the configured one.
  always_comb begin
    if (EARLY_END && (early_last_s < LAST_S)) begin
      last_s = early_last_s;
    end else begin
      last_s = LAST_S;
    end
  end

  // Next step and halt latch; a halting T2 freezes the counter where it is.
  always_comb begin
    step_nxt_s   = step_r;
    halted_nxt_s = halted_r;
    if (halt_hit_s) begin
      halted_nxt_s = 1'b1;
      step_nxt_s   = step_r;
    end else if (advance_s) begin
      if (step_r >= last_s) begin
        step_nxt_s = 3'd0;
      end else begin
        step_nxt_s = step_r + 3'd1;
      end
    end else begin
      step_nxt_s = step_r;
    end
  end

  // State register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      step_r   <= 3'd0;
      halted_r <= 1'b0;
    end else begin
      step_r   <= step_nxt_s;
      halted_r <= halted_nxt_s;
    end
  end

  // Output gating: clear wins, then halt, then the live microstep.
  always_comb begin
    if (!clr_n) begin
      ctrl_word = CW_NONE;
    end else if (halted_r) begin
      ctrl_word = CW_HLT;
    end else if (advance_s) begin
      ctrl_word = rom_word_s;
    end else begin
      ctrl_word = CW_NONE;
    end
  end

  assign step   = step_r;
  assign halted = halted_r;

endmodule
